pad_vib_sched: RTL and testbench
================================

Name: pad_vib_sched

Overview:
- Vibration scheduler in front of pad_driver's `vibrate`/`vibrate_sub` inputs.
- Shares the pad's two motors between two requesters:
  - the cartridge rumble bit (MBC5-style level signal);
  - UI haptic pulse requests (strength, small motor, duration in poll frames), buffered in a small FIFO.
- Outputs change only on poll-frame boundaries, so each SPI transaction sees stable values.

Parameters:
- QUEUE_DEPTH, 4, number of buffered UI pulse requests (power of 2, >=2).
- DUR_W, 8, width of the pulse duration field in frames.
- RUMBLE_LEVEL, 8'hC0, large-motor speed applied while cart rumble is on.

Ports:
- clk  in  1  system clock (same domain as pad_driver).
- reset  in  1  asynchronous active-high reset.
- frame_tick  in  1  one-cycle pulse at each poll-frame end (pad_driver ctr==CTR_MAX).
- pad_connect  in  1  pad present (from pad_driver).
- cart_rumble  in  1  cartridge rumble motor bit, level.
- ui_req  in  1  UI pulse request, held until acked.
- ui_strength  in  8  requested large-motor speed.
- ui_sub  in  1  requested small-motor state.
- ui_frames  in  DUR_W  pulse length in frames (0 treated as 1).
- ui_ack  out  1  request accepted this cycle (combinational).
- ui_full  out  1  FIFO full.
- ui_active  out  1  a UI pulse is currently driving the motors.
- vibrate  out  8  to pad_driver.vibrate.
- vibrate_sub  out  1  to pad_driver.vibrate_sub.

Behaviour:
- Reset (async, active-high):
  - FIFO empty; state IDLE; remaining=0.
  - vibrate=8'h00, vibrate_sub=0, ui_active=0, cart level register=0.
- Handshake: ui_ack = ui_req & (~ui_full | ~pad_connect).
  - pad_connect=1: an acked request is pushed on that clock edge.
  - pad_connect=0: acked requests are dropped, so no requester stalls.
  - When full, a push is refused even if a pop occurs in the same cycle.
- State machine (IDLE, PULSE, GAP). Transitions are taken only on frame_tick, except on disconnect.
  - IDLE, FIFO non-empty: pop the head; load strength/sub; remaining = max(frames,1) - 1; go to PULSE.
  - PULSE, remaining != 0: decrement remaining.
  - PULSE, remaining == 0: go to GAP if the FIFO is non-empty, else go to IDLE.
  - GAP: pop the head, load it, go to PULSE. The GAP gives exactly one silent frame between back-to-back pulses.
  - Result: a pulse of N frames drives the motors for exactly N frame periods.
- Cart rumble: cart_rumble is sampled into the cart level register only on frame_tick.
- Output registers update on the cycle after frame_tick:
  - vibrate = max(UI strength if in PULSE else 0, RUMBLE_LEVEL if cart level else 0).
  - vibrate_sub = ui_sub & PULSE.
  - ui_active = (state == PULSE).
- Disconnect (pad_connect=0, sampled every cycle, not only on tick), on the next edge:
  - flush the FIFO, state=IDLE, remaining=0;
  - vibrate=0, vibrate_sub=0, ui_active=0, cart level register=0.
- Reconnect: resume from IDLE on the next frame_tick.
- frame_tick and ui_req in the same cycle with an empty FIFO: the push lands, but the pop occurs on the following tick. The scheduler never bypasses the FIFO.
- Pointer wrap-around uses an extra count bit; the count range is 0..QUEUE_DEPTH.

Decomposition:
- pad_pkg, shared package:
  - enum vib_state_t {IDLE, PULSE, GAP};
  - struct vib_pulse_t {strength[7:0], sub, frames[DUR_W-1:0]};
  - localparam RUMBLE_LEVEL default.
- Sub-module pad_pulse_fifo:
  - synchronous FIFO of vib_pulse_t;
  - ports push/pop/flush/full/empty/head.

Test Plan:
- Single pulse: connect, request strength=8'h90, sub=1, frames=3 -> ui_ack=1 for one cycle. From the cycle after the next tick, vibrate=8'h90 and vibrate_sub=1 for exactly 3 tick periods, then 8'h00/0.
- Back-to-back: push (8'h40,2) and (8'hF0,1) -> 2 frames at 8'h40, 1 frame at 8'h00, 1 frame at 8'hF0, then 0; ui_active low only during the gap.
- Cart merge: cart_rumble=1 during a pulse of strength 8'h40 -> vibrate=8'hC0. With strength 8'hFF -> vibrate=8'hFF. A cart_rumble change between ticks does not alter the output until the next tick.
- Full FIFO: hold ui_req with 5 requests and no ticks -> 4 acks, ui_full=1, the 5th unacked until the first pop.
- Disconnect mid-pulse: drop pad_connect during frame 2 of 5 -> next cycle vibrate=0, FIFO empty, and new ui_req acked immediately but ignored after reconnect.
- Async reset mid-pulse and frames=0: reset clears outputs with no clock edge; a frames=0 request yields a 1-frame pulse.

Source files
------------

// File: rtl/pad_vib_sched_pkg.sv
// ============================================================================
// pad_vib_sched_pkg : shared types and defaults for the pad vibration scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

package pad_vib_sched_pkg;

    // Storage width of the frames field. The scheduler's DUR_W must not exceed this.
    localparam int         VIB_FRAMES_W         = 16;
    localparam logic [7:0] RUMBLE_LEVEL_DEFAULT = 8'hC0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } vib_state_t;

    typedef struct packed {
        logic [7:0]              strength;
        logic                    sub;
        logic [VIB_FRAMES_W-1:0] frames;
    } vib_pulse_t;

    function automatic logic [7:0] vib_max(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pad_vib_sched_if.sv
// ============================================================================
// pad_vib_sched_if : UI pulse request handshake and motor outputs
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pad_vib_sched_if #(
    parameter int DUR_W = 8
);
    logic             ui_req;
    logic [7:0]       ui_strength;
    logic             ui_sub;
    logic [DUR_W-1:0] ui_frames;
    logic             ui_ack;
    logic             ui_full;
    logic             ui_active;
    logic [7:0]       vibrate;
    logic             vibrate_sub;

    modport master (
        output ui_req, ui_strength, ui_sub, ui_frames,
        input  ui_ack, ui_full, ui_active, vibrate, vibrate_sub
    );

    modport slave (
        input  ui_req, ui_strength, ui_sub, ui_frames,
        output ui_ack, ui_full, ui_active, vibrate, vibrate_sub
    );
endinterface

`default_nettype wire

// File: rtl/pad_vib_sched_pulse_fifo.sv
// ============================================================================
// pad_vib_sched_pulse_fifo : synchronous FIFO of buffered UI pulse requests
// Revision: 1.0
// ============================================================================
`default_nettype none

module pad_vib_sched_pulse_fifo
    import pad_vib_sched_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  vib_pulse_t push_data,
    output logic       full,
    output logic       empty,
    output vib_pulse_t head
);
    localparam int AW = $clog2(QUEUE_DEPTH);

    // Pointers carry one extra bit so full and empty stay distinguishable.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic        do_push;
    logic        do_pop;
    vib_pulse_t  mem [QUEUE_DEPTH];

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (AW+1)'(QUEUE_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/pad_vib_sched.sv
// ============================================================================
// pad_vib_sched : shares the pad motors between cart rumble and UI pulses,
//                 changing outputs only on poll-frame boundaries
// Revision: 1.0
// ============================================================================
`default_nettype none

module pad_vib_sched
    import pad_vib_sched_pkg::*;
#(
    parameter int         QUEUE_DEPTH  = 4,
    parameter int         DUR_W        = 8,
    parameter logic [7:0] RUMBLE_LEVEL = RUMBLE_LEVEL_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             pad_connect,
    input  logic             cart_rumble,
    pad_vib_sched_if.slave   bus
);
    vib_state_t       state;
    logic [DUR_W-1:0] remaining;
    logic [7:0]       pulse_strength;
    logic             pulse_sub;
    logic             cart_level;
    logic             tick_d;
    logic [7:0]       vibrate_q;
    logic             vibrate_sub_q;
    logic             active_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    vib_pulse_t       push_data;
    vib_pulse_t       head;
    logic [DUR_W-1:0] load_remaining;

    // While disconnected every request is acked and dropped so nobody stalls.
    assign bus.ui_ack  = bus.ui_req & (~fifo_full | ~pad_connect);
    assign push        = bus.ui_req & ~fifo_full & pad_connect;
    assign pop         = pad_connect & frame_tick & ~fifo_empty &
                         ((state == IDLE) || (state == GAP));
    assign push_data   = '{strength: bus.ui_strength,
                           sub:      bus.ui_sub,
                           frames:   VIB_FRAMES_W'(bus.ui_frames)};

    // A zero-length request plays as a single frame.
    assign load_remaining = (head.frames == '0) ? '0
                                                : head.frames[DUR_W-1:0] - DUR_W'(1);

    pad_vib_sched_pulse_fifo #(
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (~pad_connect),
        .push_data (push_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            remaining      <= '0;
            pulse_strength <= 8'h00;
            pulse_sub      <= 1'b0;
            cart_level     <= 1'b0;
            tick_d         <= 1'b0;
            vibrate_q      <= 8'h00;
            vibrate_sub_q  <= 1'b0;
            active_q       <= 1'b0;
        end else if (!pad_connect) begin
            state          <= IDLE;
            remaining      <= '0;
            pulse_strength <= 8'h00;
            pulse_sub      <= 1'b0;
            cart_level     <= 1'b0;
            tick_d         <= 1'b0;
            vibrate_q      <= 8'h00;
            vibrate_sub_q  <= 1'b0;
            active_q       <= 1'b0;
        end else begin
            tick_d <= frame_tick;

            if (frame_tick) begin
                cart_level <= cart_rumble;
                case (state)
                    IDLE: begin
                        if (!fifo_empty) begin
                            pulse_strength <= head.strength;
                            pulse_sub      <= head.sub;
                            remaining      <= load_remaining;
                            state          <= PULSE;
                        end
                    end
                    PULSE: begin
                        if (remaining != '0) begin
                            remaining <= remaining - DUR_W'(1);
                        end else begin
                            state <= fifo_empty ? IDLE : GAP;
                        end
                    end
                    GAP: begin
                        if (!fifo_empty) begin
                            pulse_strength <= head.strength;
                            pulse_sub      <= head.sub;
                            remaining      <= load_remaining;
                            state          <= PULSE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            // Outputs follow the state one cycle after the tick.
            if (tick_d) begin
                vibrate_q     <= vib_max((state == PULSE) ? pulse_strength : 8'h00,
                                         cart_level ? RUMBLE_LEVEL : 8'h00);
                vibrate_sub_q <= pulse_sub & (state == PULSE);
                active_q      <= (state == PULSE);
            end
        end
    end

    assign bus.ui_full     = fifo_full;
    assign bus.ui_active   = active_q;
    assign bus.vibrate     = vibrate_q;
    assign bus.vibrate_sub = vibrate_sub_q;

endmodule

`default_nettype wire

// File: tb/tb_pad_vib_sched.sv
// ============================================================================
// tb_pad_vib_sched : self-checking bench with a frame-timeline reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pad_vib_sched;
    localparam int         DEPTH  = 4;
    localparam logic [7:0] RUMBLE = 8'hC0;

    logic clk = 1'b0;
    logic reset;
    logic frame_tick;
    logic pad_connect;
    logic cart_rumble;

    pad_vib_sched_if #(.DUR_W(8)) bus ();

    pad_vib_sched #(
        .QUEUE_DEPTH  (DEPTH),
        .DUR_W        (8),
        .RUMBLE_LEVEL (RUMBLE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .pad_connect (pad_connect),
        .cart_rumble (cart_rumble),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Model: a timeline of future frames; each entry is what the motors do for one frame.
    typedef struct {
        logic [7:0] s;
        logic       sub;
        logic       pulse;
        logic       start;
    } frame_t;

    frame_t     plan[$];
    frame_t     cur;
    int         cnt;
    logic       cart_m;
    logic       tick_d_m;
    logic [7:0] exp_vib;
    logic       exp_sub;
    logic       exp_act;

    int checks = 0;
    int errors = 0;

    function automatic logic exp_ack();
        return bus.ui_req & ((cnt < DEPTH) | ~pad_connect);
    endfunction

    task automatic model_reset();
        plan.delete();
        cur      = '{8'h00, 1'b0, 1'b0, 1'b0};
        cnt      = 0;
        cart_m   = 1'b0;
        tick_d_m = 1'b0;
        exp_vib  = 8'h00;
        exp_sub  = 1'b0;
        exp_act  = 1'b0;
    endtask

    task automatic model_edge();
        logic       push_ok;
        logic [7:0] a;
        logic [7:0] b;
        int         n;
        push_ok = bus.ui_req && pad_connect && (cnt < DEPTH);
        if (!pad_connect) begin
            model_reset();
            return;
        end
        if (tick_d_m) begin
            a       = cur.pulse ? cur.s : 8'h00;
            b       = cart_m ? RUMBLE : 8'h00;
            exp_vib = (a > b) ? a : b;
            exp_sub = cur.pulse & cur.sub;
            exp_act = cur.pulse;
        end
        tick_d_m = frame_tick;
        if (frame_tick) begin
            cart_m = cart_rumble;
            if (plan.size() > 0) begin
                cur = plan.pop_front();
                if (cur.start) cnt--;
            end else begin
                cur = '{8'h00, 1'b0, 1'b0, 1'b0};
            end
        end
        if (push_ok) begin
            n = (bus.ui_frames == 8'd0) ? 1 : int'(bus.ui_frames);
            // Anything still playing or queued forces one silent frame first.
            if (cur.pulse || plan.size() > 0) plan.push_back('{8'h00, 1'b0, 1'b0, 1'b0});
            for (int i = 0; i < n; i++)
                plan.push_back('{bus.ui_strength, bus.ui_sub, 1'b1, (i == 0)});
            cnt++;
        end
    endtask

    task automatic step(input logic tick);
        frame_tick = tick;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_req(input logic r, input logic [7:0] s, input logic sub, input logic [7:0] f);
        bus.ui_req      = r;
        bus.ui_strength = s;
        bus.ui_sub      = sub;
        bus.ui_frames   = f;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        frame_tick  = 1'b0;
        pad_connect = 1'b0;
        cart_rumble = 1'b0;
        set_req(1'b0, 8'h00, 1'b0, 8'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.vibrate !== 8'h00) begin
            errors++; $display("FAIL reset_vibrate got %h want 00", bus.vibrate);
        end
        checks++;
        if (bus.vibrate_sub !== 1'b0) begin
            errors++; $display("FAIL reset_sub got %b want 0", bus.vibrate_sub);
        end
        checks++;
        if (bus.ui_active !== 1'b0) begin
            errors++; $display("FAIL reset_active got %b want 0", bus.ui_active);
        end
        checks++;
        if (bus.ui_full !== 1'b0) begin
            errors++; $display("FAIL reset_full got %b want 0", bus.ui_full);
        end
        pad_connect = 1'b1;
        #1;
        checks++;
        if (bus.ui_ack !== 1'b0) begin
            errors++; $display("FAIL reset_ack got %b want 0", bus.ui_ack);
        end
    endtask

    task automatic test_single_pulse();
        int n90 = 0;
        set_req(1'b1, 8'h90, 1'b1, 8'd3);
        #1;
        checks++;
        if (bus.ui_ack !== 1'b1) begin
            errors++; $display("FAIL single_ack got %b want 1", bus.ui_ack);
        end
        step(1'b0);
        bus.ui_req = 1'b0;
        #1;
        checks++;
        if (bus.ui_ack !== 1'b0) begin
            errors++; $display("FAIL single_ack_drop got %b want 0", bus.ui_ack);
        end
        for (int c = 0; c < 32; c++) begin
            step(c % 4 == 3);
            checks++;
            if ({bus.vibrate, bus.vibrate_sub, bus.ui_active, bus.ui_full} !==
                {exp_vib, exp_sub, exp_act, (cnt == DEPTH)}) begin
                errors++;
                $display("FAIL single_out cyc %0d got %h/%b/%b/%b want %h/%b/%b/%b", c,
                         bus.vibrate, bus.vibrate_sub, bus.ui_active, bus.ui_full,
                         exp_vib, exp_sub, exp_act, (cnt == DEPTH));
            end
            if (bus.vibrate == 8'h90 && bus.vibrate_sub) n90++;
        end
        checks++;
        if (n90 != 12) begin
            errors++; $display("FAIL single_len got %0d cycles want 12", n90);
        end
    endtask

    task automatic test_back_to_back();
        int n40 = 0;
        int nf0 = 0;
        int nact = 0;
        set_req(1'b1, 8'h40, 1'b0, 8'd2);
        step(1'b0);
        set_req(1'b1, 8'hF0, 1'b0, 8'd1);
        step(1'b0);
        bus.ui_req = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step(c % 4 == 3);
            checks++;
            if ({bus.vibrate, bus.vibrate_sub, bus.ui_active, bus.ui_full} !==
                {exp_vib, exp_sub, exp_act, (cnt == DEPTH)}) begin
                errors++;
                $display("FAIL b2b_out cyc %0d got %h/%b/%b want %h/%b/%b", c,
                         bus.vibrate, bus.vibrate_sub, bus.ui_active, exp_vib, exp_sub, exp_act);
            end
            if (bus.vibrate == 8'h40) n40++;
            if (bus.vibrate == 8'hF0) nf0++;
            if (bus.ui_active) nact++;
        end
        checks++;
        if (n40 != 8 || nf0 != 4 || nact != 12) begin
            errors++;
            $display("FAIL b2b_len got 40:%0d F0:%0d act:%0d want 8 4 12", n40, nf0, nact);
        end
    endtask

    task automatic test_cart_merge();
        int nff = 0;
        cart_rumble = 1'b1;
        set_req(1'b1, 8'h40, 1'b0, 8'd3);
        step(1'b0);
        bus.ui_req = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (c == 13) cart_rumble = 1'b0;
            step(c % 4 == 3);
            checks++;
            if ({bus.vibrate, bus.vibrate_sub, bus.ui_active} !== {exp_vib, exp_sub, exp_act}) begin
                errors++;
                $display("FAIL cart_out cyc %0d got %h want %h", c, bus.vibrate, exp_vib);
            end
            if (c == 14) begin
                checks++;
                if (bus.vibrate !== 8'hC0) begin
                    errors++; $display("FAIL cart_hold got %h want c0", bus.vibrate);
                end
            end
            if (c == 17) begin
                checks++;
                if (bus.vibrate !== 8'h00) begin
                    errors++; $display("FAIL cart_off got %h want 00", bus.vibrate);
                end
            end
        end
        cart_rumble = 1'b1;
        set_req(1'b1, 8'hFF, 1'b1, 8'd2);
        step(1'b0);
        bus.ui_req = 1'b0;
        for (int c = 0; c < 24; c++) begin
            step(c % 4 == 3);
            checks++;
            if ({bus.vibrate, bus.vibrate_sub, bus.ui_active} !== {exp_vib, exp_sub, exp_act}) begin
                errors++;
                $display("FAIL cart_ff_out cyc %0d got %h want %h", c, bus.vibrate, exp_vib);
            end
            if (bus.vibrate == 8'hFF) nff++;
        end
        checks++;
        if (nff != 8) begin
            errors++; $display("FAIL cart_ff_len got %0d want 8", nff);
        end
        cart_rumble = 1'b0;
        for (int c = 0; c < 12; c++) step(c % 4 == 3);
    endtask

    task automatic test_full_fifo();
        int nack = 0;
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, 8'(8'h10 + i), 1'b0, 8'd1);
            #1;
            checks++;
            if (bus.ui_ack !== (i < 4)) begin
                errors++; $display("FAIL full_ack req %0d got %b want %b", i, bus.ui_ack, (i < 4));
            end
            if (bus.ui_ack) nack++;
            if (i < 4) step(1'b0);
        end
        checks++;
        if (bus.ui_full !== 1'b1 || nack != 4) begin
            errors++; $display("FAIL full_flag got full %b acks %0d want 1 4", bus.ui_full, nack);
        end
        step(1'b1);
        checks++;
        if (bus.ui_ack !== 1'b1 || bus.ui_full !== 1'b0) begin
            errors++;
            $display("FAIL full_after_pop got ack %b full %b want 1 0", bus.ui_ack, bus.ui_full);
        end
        step(1'b0);
        bus.ui_req = 1'b0;
        for (int c = 0; c < 60; c++) begin
            step(c % 4 == 3);
            checks++;
            if ({bus.vibrate, bus.vibrate_sub, bus.ui_active, bus.ui_full} !==
                {exp_vib, exp_sub, exp_act, (cnt == DEPTH)}) begin
                errors++;
                $display("FAIL full_drain cyc %0d got %h/%b want %h/%b", c,
                         bus.vibrate, bus.ui_active, exp_vib, exp_act);
            end
        end
    endtask

    task automatic test_disconnect();
        int nz = 0;
        set_req(1'b1, 8'h70, 1'b1, 8'd5);
        step(1'b0);
        bus.ui_req = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == 9) pad_connect = 1'b0;
            if (c == 10) begin
                set_req(1'b1, 8'hAA, 1'b1, 8'd2);
                #1;
                checks++;
                if (bus.ui_ack !== 1'b1) begin
                    errors++; $display("FAIL disc_ack got %b want 1", bus.ui_ack);
                end
            end
            if (c == 12) bus.ui_req = 1'b0;
            if (c == 13) pad_connect = 1'b1;
            step(c % 4 == 3);
            checks++;
            if ({bus.vibrate, bus.vibrate_sub, bus.ui_active, bus.ui_full} !==
                {exp_vib, exp_sub, exp_act, (cnt == DEPTH)}) begin
                errors++;
                $display("FAIL disc_out cyc %0d got %h/%b/%b want %h/%b/%b", c,
                         bus.vibrate, bus.vibrate_sub, bus.ui_active, exp_vib, exp_sub, exp_act);
            end
            if (c == 9) begin
                checks++;
                if ({bus.vibrate, bus.vibrate_sub, bus.ui_active} !== 10'h000) begin
                    errors++;
                    $display("FAIL disc_clear got %h/%b/%b want 00/0/0",
                             bus.vibrate, bus.vibrate_sub, bus.ui_active);
                end
            end
            if (c >= 9 && bus.vibrate != 8'h00) nz++;
        end
        checks++;
        if (nz != 0) begin
            errors++; $display("FAIL disc_ignored got %0d active cycles want 0", nz);
        end
    endtask

    task automatic test_async_reset_zero();
        int n33 = 0;
        set_req(1'b1, 8'h55, 1'b0, 8'd4);
        step(1'b0);
        bus.ui_req = 1'b0;
        for (int c = 0; c < 8; c++) step(c % 4 == 3);
        checks++;
        if (bus.vibrate !== 8'h55) begin
            errors++; $display("FAIL areset_pre got %h want 55", bus.vibrate);
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({bus.vibrate, bus.vibrate_sub, bus.ui_active} !== 10'h000) begin
            errors++;
            $display("FAIL areset_clear got %h/%b/%b want 00/0/0",
                     bus.vibrate, bus.vibrate_sub, bus.ui_active);
        end
        @(negedge clk);
        reset = 1'b0;
        set_req(1'b1, 8'h33, 1'b1, 8'd0);
        #1;
        step(1'b0);
        bus.ui_req = 1'b0;
        for (int c = 0; c < 24; c++) begin
            step(c % 4 == 3);
            checks++;
            if ({bus.vibrate, bus.vibrate_sub, bus.ui_active} !== {exp_vib, exp_sub, exp_act}) begin
                errors++;
                $display("FAIL zero_out cyc %0d got %h want %h", c, bus.vibrate, exp_vib);
            end
            if (bus.vibrate == 8'h33) n33++;
        end
        checks++;
        if (n33 != 4) begin
            errors++; $display("FAIL zero_len got %0d want 4", n33);
        end
    endtask

    task automatic test_random();
        logic acked = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if (acked || !bus.ui_req)
                set_req(($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)),
                        1'($urandom_range(0, 1)), 8'($urandom_range(0, 5)));
            if (pad_connect) pad_connect = ($urandom_range(0, 99) != 0);
            else             pad_connect = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) cart_rumble = ~cart_rumble;
            #1;
            checks++;
            if (bus.ui_ack !== exp_ack()) begin
                errors++; $display("FAIL rand_ack cyc %0d got %b want %b", c, bus.ui_ack, exp_ack());
            end
            acked = exp_ack();
            step($urandom_range(0, 3) == 0);
            checks++;
            if ({bus.vibrate, bus.vibrate_sub, bus.ui_active, bus.ui_full} !==
                {exp_vib, exp_sub, exp_act, (cnt == DEPTH)}) begin
                errors++;
                $display("FAIL rand_out cyc %0d got %h/%b/%b/%b want %h/%b/%b/%b", c,
                         bus.vibrate, bus.vibrate_sub, bus.ui_active, bus.ui_full,
                         exp_vib, exp_sub, exp_act, (cnt == DEPTH));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_back_to_back();
        test_cart_merge();
        test_full_fifo();
        test_disconnect();
        test_async_reset_zero();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

endmodule

`default_nettype wire
